// File: rtl/fwrisc_trace_pkg.sv
// Shared types for the instruction trace buffer: record layout, FSM states, filter modes.
package fwrisc_trace_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [5:0]      rd_waddr;
    logic [XLEN-1:0] rd_wdata;
    logic            rd_write;
    logic [XLEN-1:0] maddr;
    logic [XLEN-1:0] mdata;
    logic [3:0]      mstrb;
    logic            mwrite;
    logic            mvalid;
  } trace_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FROZEN  = 2'd3
  } trace_state_e;

  localparam logic [1:0] MODE_ALL  = 2'd0;
  localparam logic [1:0] MODE_MEM  = 2'd1;
  localparam logic [1:0] MODE_RDW  = 2'd2;
  localparam logic [1:0] MODE_DISC = 2'd3;

endpackage

// File: rtl/fwrisc_trace_fifo.sv
// Circular record store with push/pop, overwrite-oldest on full, and flush.
module fwrisc_trace_fifo
  import fwrisc_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter type rec_t = trace_rec_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   overwrite,
  input  logic                   flush,
  input  rec_t                   din,
  output rec_t                   dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   valid,
  output logic                   full_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  rec_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_pop;
  logic            do_push;
  logic            do_ovr;
  logic [CW-1:0]   count_nxt;

  // Accept/occupancy decode; an overwrite retires the oldest entry in place of a pop.
  always_comb begin
    full_c    = (count == CW'(DEPTH));
    do_pop    = pop & (count != '0);
    do_push   = push & (~full_c | do_pop | overwrite);
    do_ovr    = push & full_c & ~do_pop & overwrite;
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (do_push && !do_pop && !do_ovr)
      count_nxt = count + CW'(1);
    else if (do_pop && !do_push)
      count_nxt = count - CW'(1);
  end

  // Pointers, occupancy and registered non-empty flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      count <= count_nxt;
      valid <= (count_nxt != '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push)
          wr_ptr <= wr_ptr + AW'(1);
        if (do_pop || do_ovr)
          rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Storage array; contents are don't-care until counted in.
  always_ff @(posedge clk) begin
    if (!flush && do_push)
      mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fwrisc_trace_buffer.sv
// Retirement trace capture: filter, start trigger, freeze/wrap policy and drain stream.
module fwrisc_trace_buffer
  import fwrisc_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            pc,
  input  logic [31:0]            instr,
  input  logic                   ivalid,
  input  logic [5:0]             rd_waddr,
  input  logic [31:0]            rd_wdata,
  input  logic                   rd_write,
  input  logic [31:0]            maddr,
  input  logic [31:0]            mdata,
  input  logic [3:0]             mstrb,
  input  logic                   mwrite,
  input  logic                   mvalid,
  input  logic                   cfg_en,
  input  logic [1:0]             cfg_mode,
  input  logic                   cfg_wrap,
  input  logic                   cfg_trig_en,
  input  logic [31:0]            cfg_trig_pc,
  input  logic                   arm,
  input  logic                   disarm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output trace_rec_t             out_rec,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   triggered
);

  trace_state_e state_q;
  logic [31:0]  last_pc;
  logic         first_iv;
  logic         filt;
  logic         qual;
  logic         full;
  logic         pop;
  logic         push;
  logic         ovr;
  logic         freeze;
  logic         drop_ev;
  logic         trig_hit;
  trace_rec_t   rec;

  assign rec = '{pc: pc, instr: instr, rd_waddr: rd_waddr, rd_wdata: rd_wdata,
                 rd_write: rd_write, maddr: maddr, mdata: mdata, mstrb: mstrb,
                 mwrite: mwrite, mvalid: mvalid};

  // Qualify the retirement and decide store/overwrite/freeze for this cycle.
  always_comb begin
    unique case (cfg_mode)
      MODE_MEM:  filt = mvalid;
      MODE_RDW:  filt = rd_write & (rd_waddr != 6'd0);
      MODE_DISC: filt = first_iv | (pc != last_pc + 32'd4);
      default:   filt = 1'b1;
    endcase
    qual     = ivalid & cfg_en & filt;
    pop      = out_valid & out_ready;
    push     = 1'b0;
    ovr      = 1'b0;
    freeze   = 1'b0;
    drop_ev  = 1'b0;
    trig_hit = 1'b0;
    if (!arm && !disarm) begin
      if (state_q == ST_ARMED) begin
        if (cfg_trig_en && qual && (pc == cfg_trig_pc)) begin
          trig_hit = 1'b1;
          push     = 1'b1;
        end
      end else if (state_q == ST_CAPTURE && qual) begin
        if (!full || pop) begin
          push = 1'b1;
        end else if (cfg_wrap) begin
          push    = 1'b1;
          ovr     = 1'b1;
          drop_ev = 1'b1;
        end else begin
          freeze  = 1'b1;
          drop_ev = 1'b1;
        end
      end
    end
  end

  // Capture FSM with saturating drop counter and trigger flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      drop_cnt  <= '0;
      triggered <= 1'b0;
    end else if (arm) begin
      state_q   <= ST_ARMED;
      drop_cnt  <= '0;
      triggered <= 1'b0;
    end else if (disarm) begin
      state_q <= ST_IDLE;
    end else begin
      unique case (state_q)
        ST_ARMED: begin
          if (!cfg_trig_en) begin
            state_q <= ST_CAPTURE;
          end else if (trig_hit) begin
            state_q   <= ST_CAPTURE;
            triggered <= 1'b1;
          end
        end
        ST_CAPTURE: if (freeze) state_q <= ST_FROZEN;
        default: ;
      endcase
      if (drop_ev && (drop_cnt != {CNT_W{1'b1}}))
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  // Previous retired pc for discontinuity detection, tracked on every retirement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pc  <= '0;
      first_iv <= 1'b1;
    end else if (ivalid) begin
      last_pc  <= pc;
      first_iv <= 1'b0;
    end
  end

  assign state = state_q;

  fwrisc_trace_fifo #(
    .DEPTH (DEPTH),
    .rec_t (trace_rec_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .overwrite (ovr),
    .flush     (arm),
    .din       (rec),
    .dout      (out_rec),
    .count     (count),
    .valid     (out_valid),
    .full_c    (full)
  );

endmodule

// File: tb/tb_fwrisc_trace_buffer.sv
// Scoreboard bench for fwrisc_trace_buffer.
module tb_fwrisc_trace_buffer;
  import fwrisc_trace_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] pc, instr, rd_wdata, maddr, mdata, cfg_trig_pc;
  logic [5:0]  rd_waddr;
  logic [3:0]  mstrb;
  logic        ivalid, rd_write, mwrite, mvalid;
  logic        cfg_en, cfg_wrap, cfg_trig_en, arm, disarm;
  logic [1:0]  cfg_mode;
  logic        out_valid, out_ready, triggered;
  trace_rec_t  out_rec;
  logic [1:0]  state;
  logic [CW-1:0]    count;
  logic [CNT_W-1:0] drop_cnt;

  trace_rec_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwrisc_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr), .ivalid(ivalid),
    .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_write(rd_write),
    .maddr(maddr), .mdata(mdata), .mstrb(mstrb), .mwrite(mwrite), .mvalid(mvalid),
    .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_wrap(cfg_wrap),
    .cfg_trig_en(cfg_trig_en), .cfg_trig_pc(cfg_trig_pc),
    .arm(arm), .disarm(disarm), .out_valid(out_valid), .out_ready(out_ready),
    .out_rec(out_rec), .state(state), .count(count), .drop_cnt(drop_cnt),
    .triggered(triggered)
  );

  function automatic trace_rec_t mk_rec(input logic [31:0] p);
    trace_rec_t r;
    r.pc       = p;
    r.instr    = $urandom;
    r.rd_waddr = 6'($urandom);
    r.rd_wdata = $urandom;
    r.rd_write = 1'($urandom);
    r.maddr    = $urandom;
    r.mdata    = $urandom;
    r.mstrb    = 4'($urandom);
    r.mwrite   = 1'($urandom);
    r.mvalid   = 1'($urandom);
    return r;
  endfunction

  task automatic drive(input trace_rec_t r);
    pc = r.pc; instr = r.instr; rd_waddr = r.rd_waddr; rd_wdata = r.rd_wdata;
    rd_write = r.rd_write; maddr = r.maddr; mdata = r.mdata; mstrb = r.mstrb;
    mwrite = r.mwrite; mvalid = r.mvalid; ivalid = 1'b1;
  endtask

  task automatic retire(input trace_rec_t r, input bit exp_store);
    drive(r);
    if (exp_store) sb.push_back(r);
    @(posedge clk); #1;
    ivalid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic drain_and_check(input string name);
    trace_rec_t exp;
    int n = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 4 * DEPTH && sb.size() > 0; cyc++) begin
      if (out_valid) begin
        exp = sb.pop_front();
        checks++;
        if (out_rec !== exp) begin
          errors++;
          $display("FAIL %s rec%0d: got pc=%h instr=%h, want pc=%h instr=%h",
                   name, n, out_rec.pc, out_rec.instr, exp.pc, exp.instr);
        end
        n++;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++;
    if (sb.size() != 0 || count !== CW'(0) || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s drain_end: left=%0d count=%0d valid=%b, want 0/0/0",
               name, sb.size(), count, out_valid);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    checks++;
    if (state !== ST_IDLE || count !== CW'(0) || out_valid !== 1'b0 ||
        drop_cnt !== CNT_W'(0) || triggered !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%0d count=%0d valid=%b drop=%0d trig=%b, want 0/0/0/0/0",
               state, count, out_valid, drop_cnt, triggered);
    end
  endtask

  task automatic test_basic();
    trace_rec_t r, held;
    cfg_mode = MODE_ALL; cfg_trig_en = 1'b0; cfg_wrap = 1'b0;
    pulse_arm();
    checks++;
    if (state !== ST_ARMED) begin errors++; $display("FAIL basic_armed: state=%0d want 1", state); end
    @(posedge clk); #1;
    checks++;
    if (state !== ST_CAPTURE) begin errors++; $display("FAIL basic_capture: state=%0d want 2", state); end
    r = mk_rec(32'h200);
    drive(r);
    sb.push_back(r);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_nobypass: valid=%b want 0", out_valid); end
    @(posedge clk); #1;
    ivalid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: valid=%b want 1", out_valid); end
    for (int i = 1; i < 5; i++) retire(mk_rec(32'h200 + 32'(4 * i)), 1'b1);
    checks++;
    if (count !== CW'(5) || state !== ST_CAPTURE) begin
      errors++; $display("FAIL basic_count: count=%0d state=%0d want 5/2", count, state);
    end
    held = out_rec;
    @(posedge clk); #1;
    checks++;
    if (out_rec !== held || out_rec !== sb[0]) begin
      errors++; $display("FAIL basic_stall: pc=%h want %h", out_rec.pc, sb[0].pc);
    end
    drain_and_check("basic");
  endtask

  task automatic test_trigger();
    cfg_trig_en = 1'b1; cfg_trig_pc = 32'h100;
    pulse_arm();
    retire(mk_rec(32'hF8), 1'b0);
    retire(mk_rec(32'hFC), 1'b0);
    checks++;
    if (state !== ST_ARMED || triggered !== 1'b0 || count !== CW'(0)) begin
      errors++; $display("FAIL trig_wait: state=%0d trig=%b count=%0d want 1/0/0", state, triggered, count);
    end
    retire(mk_rec(32'h100), 1'b1);
    retire(mk_rec(32'h104), 1'b1);
    checks++;
    if (state !== ST_CAPTURE || triggered !== 1'b1 || count !== CW'(2)) begin
      errors++; $display("FAIL trig_hit: state=%0d trig=%b count=%0d want 2/1/2", state, triggered, count);
    end
    drain_and_check("trigger");
    cfg_trig_en = 1'b0;
  endtask

  task automatic test_freeze();
    cfg_wrap = 1'b0;
    pulse_arm();
    @(posedge clk); #1;
    for (int i = 0; i < 18; i++) retire(mk_rec(32'h1000 + 32'(4 * i)), i < 16);
    checks++;
    if (count !== CW'(16) || state !== ST_FROZEN || drop_cnt !== CNT_W'(1)) begin
      errors++; $display("FAIL freeze: count=%0d state=%0d drop=%0d want 16/3/1", count, state, drop_cnt);
    end
    checks++;
    if (sb[DEPTH-1].pc !== 32'h103C) begin
      errors++; $display("FAIL freeze_last: pc=%h want 0000103c", sb[DEPTH-1].pc);
    end
    drain_and_check("freeze");
    checks++;
    if (state !== ST_FROZEN) begin errors++; $display("FAIL freeze_hold: state=%0d want 3", state); end
  endtask

  task automatic run_wrap(input int n_ev, input int exp_drop, input string name);
    trace_rec_t r;
    cfg_wrap = 1'b1;
    pulse_arm();
    @(posedge clk); #1;
    for (int i = 0; i < n_ev; i++) begin
      r = mk_rec(32'h2000 + 32'(4 * i));
      if (sb.size() == DEPTH) void'(sb.pop_front());
      retire(r, 1'b1);
    end
    checks++;
    if (count !== CW'(16) || state !== ST_CAPTURE || drop_cnt !== CNT_W'(exp_drop)) begin
      errors++; $display("FAIL %s: count=%0d state=%0d drop=%0d want 16/2/%0d",
                         name, count, state, drop_cnt, exp_drop);
    end
    checks++;
    if (out_rec.pc !== 32'h2000 + 32'(4 * (n_ev - 16))) begin
      errors++; $display("FAIL %s_oldest: pc=%h want %h", name, out_rec.pc, 32'h2000 + 32'(4 * (n_ev - 16)));
    end
    drain_and_check(name);
    cfg_wrap = 1'b0;
  endtask

  task automatic test_push_pop_full();
    trace_rec_t r;
    pulse_arm();
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) retire(mk_rec(32'h3000 + 32'(4 * i)), 1'b1);
    r = mk_rec(32'h3040);
    drive(r);
    out_ready = 1'b1;
    checks++;
    if (out_rec !== sb[0]) begin errors++; $display("FAIL pp_pop: pc=%h want %h", out_rec.pc, sb[0].pc); end
    void'(sb.pop_front());
    sb.push_back(r);
    @(posedge clk); #1;
    ivalid = 1'b0; out_ready = 1'b0;
    checks++;
    if (count !== CW'(16) || state !== ST_CAPTURE || drop_cnt !== CNT_W'(0)) begin
      errors++; $display("FAIL pp_full: count=%0d state=%0d drop=%0d want 16/2/0", count, state, drop_cnt);
    end
    disarm = 1'b1;
    @(posedge clk); #1;
    disarm = 1'b0;
    checks++;
    if (state !== ST_IDLE || count !== CW'(16)) begin
      errors++; $display("FAIL disarm: state=%0d count=%0d want 0/16", state, count);
    end
    drain_and_check("pushpop");
  endtask

  task automatic test_filters();
    trace_rec_t r;
    cfg_mode = MODE_MEM;
    pulse_arm();
    @(posedge clk); #1;
    r = mk_rec(32'h4000); r.mvalid = 1'b1; retire(r, 1'b1);
    r = mk_rec(32'h4004); r.mvalid = 1'b0; retire(r, 1'b0);
    cfg_mode = MODE_RDW;
    r = mk_rec(32'h4008); r.rd_write = 1'b1; r.rd_waddr = 6'd7; retire(r, 1'b1);
    r = mk_rec(32'h400C); r.rd_write = 1'b1; r.rd_waddr = 6'd0; retire(r, 1'b0);
    r = mk_rec(32'h4010); r.rd_write = 1'b0; r.rd_waddr = 6'd3; retire(r, 1'b0);
    cfg_en = 1'b0;
    r = mk_rec(32'h4014); r.rd_write = 1'b1; r.rd_waddr = 6'd9; retire(r, 1'b0);
    cfg_en = 1'b1;
    checks++;
    if (count !== CW'(2)) begin errors++; $display("FAIL filters_count: count=%0d want 2", count); end
    drain_and_check("filters");
  endtask

  task automatic test_mode3();
    cfg_mode = MODE_DISC;
    pulse_arm();
    @(posedge clk); #1;
    retire(mk_rec(32'h0),  1'b1);
    retire(mk_rec(32'h4),  1'b0);
    retire(mk_rec(32'h40), 1'b1);
    retire(mk_rec(32'h44), 1'b0);
    retire(mk_rec(32'h8),  1'b1);
    checks++;
    if (count !== CW'(3)) begin errors++; $display("FAIL mode3_count: count=%0d want 3", count); end
    drain_and_check("mode3");
    cfg_mode = MODE_ALL;
  endtask

  task automatic test_reset_mid();
    pulse_arm();
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) retire(mk_rec(32'h5000 + 32'(4 * i)), 1'b1);
    checks++;
    if (count !== CW'(7)) begin errors++; $display("FAIL rstmid_pre: count=%0d want 7", count); end
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (count !== CW'(0) || out_valid !== 1'b0 || state !== ST_IDLE || drop_cnt !== CNT_W'(0)) begin
      errors++; $display("FAIL rstmid_async: count=%0d valid=%b state=%0d drop=%0d want 0/0/0/0",
                         count, out_valid, state, drop_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (count !== CW'(0) || out_valid !== 1'b0 || state !== ST_IDLE) begin
      errors++; $display("FAIL rstmid_after: count=%0d valid=%b state=%0d want 0/0/0", count, out_valid, state);
    end
  endtask

  initial begin
    rst_n = 1'b0; ivalid = 1'b0; pc = '0; instr = '0; rd_waddr = '0; rd_wdata = '0;
    rd_write = 1'b0; maddr = '0; mdata = '0; mstrb = '0; mwrite = 1'b0; mvalid = 1'b0;
    cfg_en = 1'b1; cfg_mode = MODE_ALL; cfg_wrap = 1'b0; cfg_trig_en = 1'b0;
    cfg_trig_pc = '0; arm = 1'b0; disarm = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_trigger();
    test_freeze();
    run_wrap(20, 4, "wrap");
    run_wrap(26, 7, "saturate");
    test_push_pop_full();
    test_filters();
    test_mode3();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwrisc_trace_buffer.md
FWRISC_TRACE_BUFFER -- requirements
Module: fwrisc_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, record storage depth; SHALL be a power of 2 and >= 2.
REQ-002 Parameter CNT_W, default 16, width of the dropped-record counter.
REQ-003 clock  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 pc, instr  in  32 each  retiring instruction address and encoding.
REQ-006 ivalid  in  1  instruction retires this cycle (execute and write-back coincide).
REQ-007 rd_waddr  in  6, rd_wdata  in  32, rd_write  in  1  destination write.
REQ-008 maddr, mdata  in  32 each, mstrb  in  4, mwrite  in  1, mvalid  in  1  memory access of the retiring instruction.
REQ-009 cfg_en  in  1  capture enable; cfg_mode  in  2  filter mode; cfg_wrap  in  1  overwrite-oldest when full; cfg_trig_en  in  1, cfg_trig_pc  in  32  start trigger.
REQ-010 arm  in  1  single-cycle pulse, flush and arm; disarm  in  1  single-cycle pulse, return to IDLE.
REQ-011 out_valid  out  1, out_ready  in  1, out_rec  out  trace_rec_t  drain stream.
REQ-012 state  out  2, count  out  $clog2(DEPTH)+1, drop_cnt  out  CNT_W, triggered  out  1  status.

Function
REQ-013 Record = {pc, instr, rd_waddr, rd_wdata, rd_write, maddr, mdata, mstrb, mwrite, mvalid} of the qualifying cycle.
REQ-014 Qualifying event = ivalid & cfg_en & filter, where filter is: mode 0 all retirements; mode 1 mvalid; mode 2 rd_write & rd_waddr != 0; mode 3 pc != last_pc+4 (control-flow discontinuity).
REQ-015 last_pc SHALL update on every ivalid regardless of filter or state; the first ivalid after reset counts as a discontinuity in mode 3.
REQ-016 FSM states IDLE=0, ARMED=1, CAPTURE=2, FROZEN=3; only CAPTURE stores records.
REQ-017 IDLE -> ARMED on arm; ARMED -> CAPTURE next cycle when cfg_trig_en=0, else on a qualifying event with pc == cfg_trig_pc, that event being stored and triggered set to 1.
REQ-018 CAPTURE -> FROZEN when a qualifying event finds the buffer full and cfg_wrap=0; that event is not stored and drop_cnt increments.
REQ-019 Full with cfg_wrap=1: the oldest record is discarded, the new one stored, count unchanged, drop_cnt increments.
REQ-020 arm in any state: flush buffer, clear drop_cnt and triggered, enter ARMED; disarm in any state enters IDLE and keeps buffer contents; arm takes priority over disarm.
REQ-021 Store latency: a record captured in cycle N is visible on out_rec with out_valid no earlier than cycle N+1; no same-cycle bypass.
REQ-022 Pop occurs when out_valid & out_ready; draining is permitted in every state; out_rec holds stable while out_valid & !out_ready.
REQ-023 Simultaneous push and pop when full: both occur, count unchanged, no drop, no freeze.
REQ-024 drop_cnt saturates at all-ones.
REQ-025 count = number of stored records, 0..DEPTH; out_valid = (count != 0).

Reset
REQ-026 On reset low: state=IDLE, count=0, out_valid=0, drop_cnt=0, triggered=0, pointers=0, last_pc=0, first-ivalid flag set.
REQ-027 Reset asserted mid-capture or mid-drain SHALL discard all stored records; storage array contents need no reset.

Structure
REQ-028 Package fwrisc_trace_pkg SHALL hold trace_rec_t (packed struct), the state enum and the cfg_mode encodings.
REQ-029 Storage SHALL be one sub-module fwrisc_trace_fifo (DEPTH, record type; push, pop, overwrite, flush, count).

Verification
REQ-030 Mode 0, no trigger, arm, 5 retirements with out_ready=0 -> count=5, state=CAPTURE; then out_ready=1 -> 5 records in order, count 0.
REQ-031 cfg_trig_en=1, cfg_trig_pc=0x100, pc sequence 0xF8,0xFC,0x100,0x104 -> records 0x100,0x104 only, triggered=1.
REQ-032 DEPTH=16, cfg_wrap=0, 18 events, no drain -> count=16, state=FROZEN, drop_cnt=1, last stored pc is the 16th.
REQ-033 DEPTH=16, cfg_wrap=1, 20 events -> count=16, drop_cnt=4, first drained record is the 5th event.
REQ-034 Mode 3, pc sequence 0x0,0x4,0x40,0x44,0x8 -> records 0x0,0x40,0x8.
REQ-035 Reset asserted with count=7 during a drain stall -> next cycle count=0, out_valid=0, state=IDLE, drop_cnt=0.
